// File: rtl/pipe_32_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_32_p_if
//  Brief    : Control, program-load, debug and retire bus of pipe_32_p.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_32_p_if #(
    parameter int XLEN = 32,
    parameter int AW   = 10
);
    logic            start;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [XLEN-1:0] prog_wdata;
    logic [4:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            busy;
    logic            halted;
    logic            illegal;
    logic            retire_valid;
    logic [AW-1:0]   retire_pc;
    logic [31:0]     instr_cnt;

    modport master (
        output start, prog_we, prog_addr, prog_wdata, dbg_raddr,
        input  dbg_rdata, busy, halted, illegal, retire_valid, retire_pc, instr_cnt
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_wdata, dbg_raddr,
        output dbg_rdata, busy, halted, illegal, retire_valid, retire_pc, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_32_p.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_32_p
//  Brief    : Five-stage in-order pipeline with unified word memory,
//             optional operand forwarding and a run/halt controller.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_32_p #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int FWD_EN    = 1
) (
    input  wire logic  clk1,
    input  wire logic  rst_n,
    pipe_32_p_if.slave bus
);
    localparam int c_aw = $clog2(MEM_DEPTH);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    localparam logic [5:0] c_op_add   = 6'b000000;
    localparam logic [5:0] c_op_sub   = 6'b000001;
    localparam logic [5:0] c_op_and   = 6'b000010;
    localparam logic [5:0] c_op_or    = 6'b000011;
    localparam logic [5:0] c_op_slt   = 6'b000100;
    localparam logic [5:0] c_op_mul   = 6'b000101;
    localparam logic [5:0] c_op_lw    = 6'b001000;
    localparam logic [5:0] c_op_sw    = 6'b001001;
    localparam logic [5:0] c_op_addi  = 6'b001010;
    localparam logic [5:0] c_op_subi  = 6'b001011;
    localparam logic [5:0] c_op_slti  = 6'b001100;
    localparam logic [5:0] c_op_bneqz = 6'b001101;
    localparam logic [5:0] c_op_beqz  = 6'b001110;
    localparam logic [5:0] c_op_hlt   = 6'b111111;

    function automatic logic f_legal(input logic [5:0] op);
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul,
            c_op_lw, c_op_sw, c_op_addi, c_op_subi, c_op_slti,
            c_op_bneqz, c_op_beqz, c_op_hlt: f_legal = 1'b1;
            default:                         f_legal = 1'b0;
        endcase
    endfunction

    // Destination register; 0 means the instruction writes nothing.
    function automatic logic [4:0] f_dst(input logic [31:0] ir);
        case (ir[31:26])
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul:
                f_dst = ir[15:11];
            c_op_lw, c_op_addi, c_op_subi, c_op_slti:
                f_dst = ir[20:16];
            default:
                f_dst = 5'd0;
        endcase
    endfunction

    function automatic logic f_uses_rs(input logic [31:0] ir);
        case (ir[31:26])
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul,
            c_op_lw, c_op_sw, c_op_addi, c_op_subi, c_op_slti,
            c_op_bneqz, c_op_beqz: f_uses_rs = 1'b1;
            default:               f_uses_rs = 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rt(input logic [31:0] ir);
        case (ir[31:26])
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul,
            c_op_sw: f_uses_rt = 1'b1;
            default: f_uses_rt = 1'b0;
        endcase
    endfunction

    logic [1:0]      r_state;
    logic [c_aw-1:0] r_pc;
    logic            r_fetch_stop;
    logic            r_illegal;
    logic [31:0]     r_instr_cnt;

    logic            r_ifid_v;
    logic [31:0]     r_ifid_ir;
    logic [c_aw-1:0] r_ifid_pc;

    logic            r_idex_v;
    logic [31:0]     r_idex_ir;
    logic [c_aw-1:0] r_idex_pc;
    logic [XLEN-1:0] r_idex_a;
    logic [XLEN-1:0] r_idex_b;

    logic            r_exmem_v;
    logic [31:0]     r_exmem_ir;
    logic [c_aw-1:0] r_exmem_pc;
    logic [XLEN-1:0] r_exmem_alu;
    logic [XLEN-1:0] r_exmem_sd;

    logic            r_memwb_v;
    logic [31:0]     r_memwb_ir;
    logic [c_aw-1:0] r_memwb_pc;
    logic [XLEN-1:0] r_memwb_val;

    logic [XLEN-1:0] r_rf  [32];
    logic [XLEN-1:0] r_mem [MEM_DEPTH];

    // ---------------- ID: register read with write-first bypass ----------
    logic [4:0]      w_id_rs, w_id_rt, w_wb_dst, w_ex_dst, w_mem_dst;
    logic [XLEN-1:0] w_id_a, w_id_b;
    logic            w_rs_use, w_rt_use, w_hz_ex, w_hz_mem, w_stall, w_id_halt;

    assign w_id_rs  = r_ifid_ir[25:21];
    assign w_id_rt  = r_ifid_ir[20:16];
    assign w_wb_dst  = r_memwb_v ? f_dst(r_memwb_ir) : 5'd0;
    assign w_ex_dst  = r_idex_v  ? f_dst(r_idex_ir)  : 5'd0;
    assign w_mem_dst = r_exmem_v ? f_dst(r_exmem_ir) : 5'd0;

    assign w_id_a = (w_id_rs == 5'd0) ? '0 :
                    (w_wb_dst == w_id_rs) ? r_memwb_val : r_rf[w_id_rs];
    assign w_id_b = (w_id_rt == 5'd0) ? '0 :
                    (w_wb_dst == w_id_rt) ? r_memwb_val : r_rf[w_id_rt];

    assign w_rs_use = r_ifid_v && f_uses_rs(r_ifid_ir) && (w_id_rs != 5'd0);
    assign w_rt_use = r_ifid_v && f_uses_rt(r_ifid_ir) && (w_id_rt != 5'd0);
    assign w_hz_ex  = (w_ex_dst != 5'd0) &&
                      ((w_rs_use && w_ex_dst == w_id_rs) || (w_rt_use && w_ex_dst == w_id_rt));
    assign w_hz_mem = (w_mem_dst != 5'd0) &&
                      ((w_rs_use && w_mem_dst == w_id_rs) || (w_rt_use && w_mem_dst == w_id_rt));
    assign w_stall  = (FWD_EN != 0) ? (w_hz_ex && r_idex_ir[31:26] == c_op_lw)
                                    : (w_hz_ex || w_hz_mem);
    assign w_id_halt = r_ifid_v &&
                       (r_ifid_ir[31:26] == c_op_hlt || !f_legal(r_ifid_ir[31:26]));

    // ---------------- EX: forwarding, ALU, branch resolve ----------------
    logic [4:0]      w_ex_rs, w_ex_rt, w_exmem_fwd_dst;
    logic [XLEN-1:0] w_ex_a, w_ex_b, w_imm, w_alu;
    logic            w_flush;
    logic [c_aw-1:0] w_target;

    assign w_ex_rs = r_idex_ir[25:21];
    assign w_ex_rt = r_idex_ir[20:16];
    assign w_imm   = {{(XLEN-16){r_idex_ir[15]}}, r_idex_ir[15:0]};
    // Load results are not yet available in EX/MEM; load-use stall covers it.
    assign w_exmem_fwd_dst = (r_exmem_ir[31:26] == c_op_lw) ? 5'd0 : w_mem_dst;

    always_comb begin
        w_ex_a = r_idex_a;
        w_ex_b = r_idex_b;
        if (FWD_EN != 0) begin
            if (w_ex_rs != 5'd0 && w_exmem_fwd_dst == w_ex_rs)
                w_ex_a = r_exmem_alu;
            else if (w_ex_rs != 5'd0 && w_wb_dst == w_ex_rs)
                w_ex_a = r_memwb_val;
            if (w_ex_rt != 5'd0 && w_exmem_fwd_dst == w_ex_rt)
                w_ex_b = r_exmem_alu;
            else if (w_ex_rt != 5'd0 && w_wb_dst == w_ex_rt)
                w_ex_b = r_memwb_val;
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_idex_ir[31:26])
            c_op_add:  w_alu = w_ex_a + w_ex_b;
            c_op_sub:  w_alu = w_ex_a - w_ex_b;
            c_op_and:  w_alu = w_ex_a & w_ex_b;
            c_op_or:   w_alu = w_ex_a | w_ex_b;
            c_op_slt:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_ex_a) < $signed(w_ex_b))};
            c_op_mul:  w_alu = w_ex_a * w_ex_b;
            c_op_lw, c_op_sw, c_op_addi:
                       w_alu = w_ex_a + w_imm;
            c_op_subi: w_alu = w_ex_a - w_imm;
            c_op_slti: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_ex_a) < $signed(w_imm))};
            default:   w_alu = '0;
        endcase
    end

    assign w_flush  = r_idex_v &&
                      ((r_idex_ir[31:26] == c_op_beqz  && w_ex_a == '0) ||
                       (r_idex_ir[31:26] == c_op_bneqz && w_ex_a != '0));
    assign w_target = r_idex_pc + c_aw'(1) + w_imm[c_aw-1:0];

    // ---------------- MEM / WB ----------------
    logic [c_aw-1:0] w_mem_addr;
    logic [XLEN-1:0] w_mem_val;
    logic            w_retire, w_wb_hlt, w_wb_ill;

    assign w_mem_addr = r_exmem_alu[c_aw-1:0];
    assign w_mem_val  = (r_exmem_ir[31:26] == c_op_lw) ? r_mem[w_mem_addr] : r_exmem_alu;
    assign w_wb_hlt   = r_memwb_v && r_memwb_ir[31:26] == c_op_hlt;
    assign w_wb_ill   = r_memwb_v && !f_legal(r_memwb_ir[31:26]);
    // An undefined opcode halts the machine but is not counted as retired.
    assign w_retire   = r_memwb_v && !w_wb_ill;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_pc         <= '0;
            r_fetch_stop <= 1'b0;
            r_illegal    <= 1'b0;
            r_instr_cnt  <= '0;
            r_ifid_v     <= 1'b0;
            r_idex_v     <= 1'b0;
            r_exmem_v    <= 1'b0;
            r_memwb_v    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_halted: begin
                    if (bus.start) begin
                        r_state      <= c_st_run;
                        r_pc         <= '0;
                        r_fetch_stop <= 1'b0;
                        r_illegal    <= 1'b0;
                        r_instr_cnt  <= '0;
                        r_ifid_v     <= 1'b0;
                        r_idex_v     <= 1'b0;
                        r_exmem_v    <= 1'b0;
                        r_memwb_v    <= 1'b0;
                    end
                end
                c_st_run: begin
                    r_instr_cnt <= r_instr_cnt + {31'd0, w_retire};
                    if (w_wb_hlt || w_wb_ill) begin
                        r_state   <= c_st_halted;
                        r_illegal <= w_wb_ill;
                        r_ifid_v  <= 1'b0;
                        r_idex_v  <= 1'b0;
                        r_exmem_v <= 1'b0;
                        r_memwb_v <= 1'b0;
                    end else begin
                        r_memwb_v   <= r_exmem_v;
                        r_memwb_ir  <= r_exmem_ir;
                        r_memwb_pc  <= r_exmem_pc;
                        r_memwb_val <= w_mem_val;
                        r_exmem_v   <= r_idex_v;
                        r_exmem_ir  <= r_idex_ir;
                        r_exmem_pc  <= r_idex_pc;
                        r_exmem_alu <= w_alu;
                        r_exmem_sd  <= w_ex_b;
                        if (w_flush) begin
                            r_pc         <= w_target;
                            r_ifid_v     <= 1'b0;
                            r_idex_v     <= 1'b0;
                            r_fetch_stop <= 1'b0;
                        end else if (w_stall) begin
                            r_idex_v <= 1'b0;
                        end else begin
                            r_idex_v  <= r_ifid_v;
                            r_idex_ir <= r_ifid_ir;
                            r_idex_pc <= r_ifid_pc;
                            r_idex_a  <= w_id_a;
                            r_idex_b  <= w_id_b;
                            // HLT/illegal in ID freezes fetch until the next start.
                            if (w_id_halt || r_fetch_stop) begin
                                r_ifid_v     <= 1'b0;
                                r_fetch_stop <= 1'b1;
                            end else begin
                                r_ifid_v  <= 1'b1;
                                r_ifid_ir <= r_mem[r_pc][31:0];
                                r_ifid_pc <= r_pc;
                                r_pc      <= r_pc + c_aw'(1);
                            end
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (r_state != c_st_run) begin
            if (bus.prog_we)
                r_mem[bus.prog_addr] <= bus.prog_wdata;
        end else if (rst_n && r_exmem_v && r_exmem_ir[31:26] == c_op_sw) begin
            r_mem[w_mem_addr] <= r_exmem_sd;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst_n && r_state == c_st_run && w_wb_dst != 5'd0)
            r_rf[w_wb_dst] <= r_memwb_val;
    end

    assign bus.dbg_rdata    = (bus.dbg_raddr == 5'd0) ? '0 : r_rf[bus.dbg_raddr];
    assign bus.busy         = (r_state == c_st_run);
    assign bus.halted       = (r_state == c_st_halted);
    assign bus.illegal      = r_illegal;
    assign bus.retire_valid = w_retire;
    assign bus.retire_pc    = r_memwb_pc;
    assign bus.instr_cnt    = r_instr_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_32_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_32_p
//  Brief    : Directed bench running each program on a 32-bit forwarding
//             core and a 64-bit stalling core side by side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_32_p;
    logic        clk1 = 1'b0;
    logic        rst_n, start, prog_we;
    logic [9:0]  prog_addr;
    logic [63:0] prog_wdata;
    logic [4:0]  dbg_raddr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [9:0]  q32[$], q64[$];
    int          c32[$], c64[$];
    logic [31:0] prog[$];
    logic [31:0] s32, s64;

    always #5 clk1 = ~clk1;

    pipe_32_p_if #(.XLEN(32), .AW(10)) if32 ();
    pipe_32_p_if #(.XLEN(64), .AW(10)) if64 ();

    assign if32.start      = start;
    assign if32.prog_we    = prog_we;
    assign if32.prog_addr  = prog_addr;
    assign if32.prog_wdata = prog_wdata[31:0];
    assign if32.dbg_raddr  = dbg_raddr;
    assign if64.start      = start;
    assign if64.prog_we    = prog_we;
    assign if64.prog_addr  = prog_addr;
    assign if64.prog_wdata = prog_wdata;
    assign if64.dbg_raddr  = dbg_raddr;

    pipe_32_p #(.XLEN(32), .MEM_DEPTH(1024), .FWD_EN(1)) dut32 (
        .clk1 (clk1), .rst_n (rst_n), .bus (if32.slave));
    pipe_32_p #(.XLEN(64), .MEM_DEPTH(1024), .FWD_EN(0)) dut64 (
        .clk1 (clk1), .rst_n (rst_n), .bus (if64.slave));

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (if32.retire_valid) begin q32.push_back(if32.retire_pc); c32.push_back(cyc); end
        if (if64.retire_valid) begin q64.push_back(if64.retire_pc); c64.push_back(cyc); end
    end

    function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
        enc_r = {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        enc_i = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [63:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr[9:0];
        prog_wdata = data;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) wr(i, {32'd0, prog[i]});
    endtask

    task automatic kick();
        q32.delete(); q64.delete(); c32.delete(); c64.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int maxc);
        for (int i = 0; i < maxc && !(if32.halted && if64.halted); i++) tick();
        check("halt_timeout", {63'd0, if32.halted & if64.halted}, 64'd1);
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [63:0] e32, input logic [63:0] e64);
        dbg_raddr = r[4:0];
        #1;
        check({tag, "_32"}, {32'd0, if32.dbg_rdata}, e32);
        check({tag, "_64"}, if64.dbg_rdata, e64);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_wdata = '0; dbg_raddr = '0;
        repeat (3) tick();
        check("rst_busy",    {62'd0, if32.busy, if64.busy}, 64'd0);
        check("rst_halted",  {62'd0, if32.halted, if64.halted}, 64'd0);
        check("rst_illegal", {62'd0, if32.illegal, if64.illegal}, 64'd0);
        check("rst_retire",  {62'd0, if32.retire_valid, if64.retire_valid}, 64'd0);
        check("rst_cnt",     {if32.instr_cnt, if64.instr_cnt}, 64'd0);
        rst_n = 1'b1;
        tick();

        // ADDI/ADDI/ADD/HLT
        prog.delete();
        prog.push_back(enc_i(10, 0, 1, 10));
        prog.push_back(enc_i(10, 0, 2, 20));
        prog.push_back(enc_r(0, 1, 2, 3));
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        check("t1_busy", {62'd0, if32.busy, if64.busy}, 64'd3);
        wait_halt(200);
        chk_reg("t1_r3", 3, 64'd30, 64'd30);
        check("t1_cnt", {if32.instr_cnt, if64.instr_cnt}, {32'd4, 32'd4});
        check("t1_span32", 64'(c32[3] - c32[0]), 64'd3);
        check("t1_span64", 64'(c64[3] - c64[0]), 64'd5);

        // LW then dependent ADD
        wr(100, 64'd7);
        prog.delete();
        prog.push_back(enc_i(8, 0, 1, 100));
        prog.push_back(enc_r(0, 1, 1, 2));
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        wait_halt(200);
        chk_reg("t2_r2", 2, 64'd14, 64'd14);
        check("t2_gap32", 64'(c32[1] - c32[0]), 64'd2);
        check("t2_gap64", 64'(c64[1] - c64[0]), 64'd3);

        // Countdown loop; mid-run start and prog_we must be ignored
        prog.delete();
        prog.push_back(enc_i(10, 0, 1, 3));
        prog.push_back(enc_i(11, 1, 1, 1));
        prog.push_back(enc_i(13, 1, 0, -2));
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        repeat (3) tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 10'd3; prog_wdata = 64'h5400_0000;
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_halt(300);
        chk_reg("t3_r1", 1, 64'd0, 64'd0);
        check("t3_cnt", {if32.instr_cnt, if64.instr_cnt}, {32'd8, 32'd8});
        check("t3_illegal", {62'd0, if32.illegal, if64.illegal}, 64'd0);
        s32 = '0; s64 = '0;
        foreach (q32[i]) s32 = {s32[27:0], q32[i][3:0]};
        foreach (q64[i]) s64 = {s64[27:0], q64[i][3:0]};
        check("t3_seq", {s32, s64}, {32'h0121_2123, 32'h0121_2123});
        check("t3_penalty32", 64'(c32[3] - c32[2]), 64'd3);

        // MUL width, store/load, signed compares, logic ops, taken BEQZ, R0 write
        prog.delete();
        prog.push_back(enc_i(10, 0, 1, 256));
        prog.push_back(enc_i(10, 0, 4, 2));
        prog.push_back(enc_r(5, 1, 1, 2));
        prog.push_back(enc_r(5, 2, 2, 3));
        prog.push_back(enc_r(5, 3, 4, 5));
        prog.push_back(enc_i(9, 0, 5, 200));
        prog.push_back(enc_i(8, 0, 6, 200));
        prog.push_back(enc_i(11, 0, 8, 5));
        prog.push_back(enc_i(12, 8, 9, -4));
        prog.push_back(enc_r(4, 8, 1, 10));
        prog.push_back(enc_r(3, 1, 4, 11));
        prog.push_back(enc_r(2, 11, 1, 12));
        prog.push_back(enc_r(1, 4, 1, 13));
        prog.push_back(enc_i(14, 0, 0, 1));
        prog.push_back(enc_i(10, 0, 14, 99));
        prog.push_back(enc_i(10, 0, 0, 5));
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        wait_halt(400);
        chk_reg("t4_r2", 2, 64'd65536, 64'd65536);
        chk_reg("t4_r5", 5, 64'd0, 64'h2_0000_0000);
        chk_reg("t4_r6", 6, 64'd0, 64'h2_0000_0000);
        chk_reg("t4_r9", 9, 64'd1, 64'd1);
        chk_reg("t4_r10", 10, 64'd1, 64'd1);
        chk_reg("t4_r12", 12, 64'd256, 64'd256);
        chk_reg("t4_r13", 13, 64'hFFFF_FF02, 64'hFFFF_FFFF_FFFF_FF02);
        chk_reg("t4_r0", 0, 64'd0, 64'd0);
        check("t4_cnt", {if32.instr_cnt, if64.instr_cnt}, {32'd16, 32'd16});

        // Undefined opcode at address 2
        prog.delete();
        prog.push_back(enc_i(10, 0, 1, 1));
        prog.push_back(enc_i(10, 0, 2, 2));
        prog.push_back(32'h5400_0000);
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        wait_halt(200);
        check("t5_illegal", {62'd0, if32.illegal, if64.illegal}, 64'd3);
        check("t5_cnt", {if32.instr_cnt, if64.instr_cnt}, {32'd2, 32'd2});
        check("t5_retired", 64'(q32.size() + q64.size()), 64'd4);
        chk_reg("t5_r2", 2, 64'd2, 64'd2);

        // Reset in the middle of the loop, then rerun
        prog.delete();
        prog.push_back(enc_i(10, 0, 1, 3));
        prog.push_back(enc_i(11, 1, 1, 1));
        prog.push_back(enc_i(13, 1, 0, -2));
        prog.push_back(32'hFC00_0000);
        load_prog();
        kick();
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("t6_busy",   {62'd0, if32.busy, if64.busy}, 64'd0);
        check("t6_retire", {62'd0, if32.retire_valid, if64.retire_valid}, 64'd0);
        check("t6_cnt",    {if32.instr_cnt, if64.instr_cnt}, 64'd0);
        check("t6_halted", {62'd0, if32.halted, if64.halted}, 64'd0);
        rst_n = 1'b1;
        tick();
        kick();
        wait_halt(300);
        chk_reg("t6_r1", 1, 64'd0, 64'd0);
        check("t6_rerun_cnt", {if32.instr_cnt, if64.instr_cnt}, {32'd8, 32'd8});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
